plru_tree_array: RTL and testbench

Parametrised tree-PLRU replacement unit for a WAYS-way, SETS-set associative cache.
- Holds per-set PLRU state in flops.
- Returns a registered victim way for a looked-up set.
- Prefers invalid ways over the PLRU choice.
- Applies hit and fill updates with same-cycle forwarding.
- Sits beside the cache tag array; the cache controller drives the lookup port on a miss and the update port on every hit or fill.

---
 rtl/plru_pkg.sv | 80 ++++++++
 rtl/plru_tree_logic.sv | 25 ++
 rtl/plru_tree_array.sv | 91 +++++++++
 tb/tb_plru_tree_array.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/plru_pkg.sv
// plru_pkg: shared tree-PLRU helpers for WAYS-way caches.
// State vectors are carried at a maximum width (MAX_WAYS-1 node bits) and the
// real associativity is passed as an argument, so one set of functions serves
// every cache block regardless of its WAYS parameter. With a constant 'ways'
// argument, the loops unroll into plain combinational logic.
//   plru_left/right : heap child index of a node
//   plru_is_pow2    : legality check for WAYS/SETS
//   plru_victim     : lowest invalid way, else walk node bits from the root
//   plru_touch      : point every node on the way's path away from it
package plru_pkg;

  localparam int MAX_WAYS   = 64;
  localparam int MAX_NODES  = MAX_WAYS - 1;
  localparam int MAX_LEVELS = 6;

  typedef logic [MAX_NODES-1:0] plru_state_t;
  typedef logic [MAX_WAYS-1:0]  plru_mask_t;

  function automatic int plru_left(input int n);
    return 2 * n + 1;
  endfunction

  function automatic int plru_right(input int n);
    return 2 * n + 2;
  endfunction

  function automatic bit plru_is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int plru_victim(input int ways, input plru_state_t state,
                                     input plru_mask_t valid_mask);
    int  way;
    int  node;
    int  levels;
    bit  found;
    way    = 0;
    node   = 0;
    found  = 1'b0;
    levels = $clog2(ways);
    for (int w = 0; w < MAX_WAYS; w++) begin
      if (w < ways && !found && !valid_mask[w]) begin
        way   = w;
        found = 1'b1;
      end
    end
    if (!found) begin
      for (int lvl = 0; lvl < MAX_LEVELS; lvl++) begin
        if (lvl < levels) begin
          node = state[node] ? plru_right(node) : plru_left(node);
        end
      end
      // Leaves occupy heap indices ways-1 .. 2*ways-2, left to right.
      way = node - (ways - 1);
    end
    return way;
  endfunction

  function automatic plru_state_t plru_touch(input int ways, input plru_state_t state,
                                             input int way);
    plru_state_t next;
    int          node;
    int          levels;
    bit          go_right;
    next   = state;
    node   = 0;
    levels = $clog2(ways);
    for (int lvl = 0; lvl < MAX_LEVELS; lvl++) begin
      if (lvl < levels) begin
        // Way index bits, MSB first, select the branch at each level.
        go_right   = ((way >> (levels - 1 - lvl)) & 1) != 0;
        // Accessed on the right -> LRU side is left (0), and vice versa.
        next[node] = !go_right;
        node       = go_right ? plru_right(node) : plru_left(node);
      end
    end
    return next;
  endfunction

endpackage

// File: rtl/plru_tree_logic.sv
// plru_tree_logic: combinational PLRU logic for one set.
//   state_i      : node bits of the set (heap order)
//   valid_mask_i : valid bits, bit w = way w
//   touch_way_i  : way being accessed
//   victim_o     : way to replace for this state/mask
//   next_state_o : state after touching touch_way_i
module plru_tree_logic
  import plru_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  state_i,
  input  logic [WAYS-1:0]  valid_mask_i,
  input  logic [WAY_W-1:0] touch_way_i,
  output logic [WAY_W-1:0] victim_o,
  output logic [WAYS-2:0]  next_state_o
);

  assign victim_o     = WAY_W'(plru_victim(WAYS, plru_state_t'(state_i),
                                           plru_mask_t'(valid_mask_i)));
  assign next_state_o = (WAYS-1)'(plru_touch(WAYS, plru_state_t'(state_i),
                                             int'(touch_way_i)));

endmodule

// File: rtl/plru_tree_array.sv
// plru_tree_array: per-set tree-PLRU state with registered victim output.
//   clk_i, rst_n_i          : clock, synchronous active-low reset
//   lookup_valid_i/set_i    : victim request for a set
//   way_valid_i             : valid bits of the looked-up set
//   victim_valid_o/way_o    : victim, one cycle after the lookup
//   update_valid_i/set_i/way_i : hit or fill access to record
module plru_tree_array
  import plru_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int SETS  = 16,
  parameter int WAY_W = $clog2(WAYS),
  parameter int SET_W = $clog2(SETS)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             lookup_valid_i,
  input  logic [SET_W-1:0] lookup_set_i,
  input  logic [WAYS-1:0]  way_valid_i,
  output logic             victim_valid_o,
  output logic [WAY_W-1:0] victim_way_o,
  input  logic             update_valid_i,
  input  logic [SET_W-1:0] update_set_i,
  input  logic [WAY_W-1:0] update_way_i
);

  generate
    if (!plru_is_pow2(WAYS) || WAYS > MAX_WAYS) begin : g_bad_ways
      $error("plru_tree_array: WAYS must be a power of 2 in 2..%0d", MAX_WAYS);
    end
    if (!plru_is_pow2(SETS)) begin : g_bad_sets
      $error("plru_tree_array: SETS must be a power of 2, at least 2");
    end
  endgenerate

  logic [WAYS-2:0]  state_q [SETS];
  logic [WAYS-2:0]  upd_state_d;
  logic [WAYS-2:0]  lkp_state;
  logic [WAY_W-1:0] victim_d;
  logic [WAY_W-1:0] victim_way_q;
  logic             victim_valid_q;
  logic [WAY_W-1:0] upd_victim_unused;
  logic [WAYS-2:0]  lkp_next_unused;

  plru_tree_logic #(.WAYS(WAYS), .WAY_W(WAY_W)) u_update (
    .state_i      (state_q[update_set_i]),
    .valid_mask_i ({WAYS{1'b1}}),
    .touch_way_i  (update_way_i),
    .victim_o     (upd_victim_unused),
    .next_state_o (upd_state_d)
  );

  // A same-cycle update to the looked-up set is forwarded so the victim
  // reflects the access the controller is recording right now.
  assign lkp_state = (update_valid_i && update_set_i == lookup_set_i)
                     ? upd_state_d : state_q[lookup_set_i];

  plru_tree_logic #(.WAYS(WAYS), .WAY_W(WAY_W)) u_lookup (
    .state_i      (lkp_state),
    .valid_mask_i (way_valid_i),
    .touch_way_i  ('0),
    .victim_o     (victim_d),
    .next_state_o (lkp_next_unused)
  );

  always_ff @(posedge clk_i) begin
    for (int s = 0; s < SETS; s++) begin
      if (!rst_n_i) begin
        state_q[s] <= '0;
      end else if (update_valid_i && update_set_i == SET_W'(s)) begin
        state_q[s] <= upd_state_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
    end else begin
      victim_valid_q <= lookup_valid_i;
      if (lookup_valid_i) begin
        victim_way_q <= victim_d;
      end
    end
  end

  assign victim_valid_o = victim_valid_q;
  assign victim_way_o   = victim_way_q;

endmodule

// File: tb/tb_plru_tree_array.sv
// tb_plru_tree_array: directed + random checks of two plru_tree_array
// instances (4-way/16-set and 8-way/4-set). The reference model keeps a
// last-access timestamp per way; the PLRU choice at any subtree goes to the
// half whose most recent access is older (left on a tie).
module tb_plru_tree_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: WAYS=4, SETS=16
  logic       a_rst_n, a_lv, a_vv, a_uv;
  logic [3:0] a_ls, a_vm, a_us;
  logic [1:0] a_vw, a_uw;
  // DUT B: WAYS=8, SETS=4
  logic       b_rst_n, b_lv, b_vv, b_uv;
  logic [1:0] b_ls, b_us;
  logic [7:0] b_vm;
  logic [2:0] b_vw, b_uw;

  plru_tree_array #(.WAYS(4), .SETS(16)) u_dut_a (
    .clk_i(clk), .rst_n_i(a_rst_n),
    .lookup_valid_i(a_lv), .lookup_set_i(a_ls), .way_valid_i(a_vm),
    .victim_valid_o(a_vv), .victim_way_o(a_vw),
    .update_valid_i(a_uv), .update_set_i(a_us), .update_way_i(a_uw)
  );

  plru_tree_array #(.WAYS(8), .SETS(4)) u_dut_b (
    .clk_i(clk), .rst_n_i(b_rst_n),
    .lookup_valid_i(b_lv), .lookup_set_i(b_ls), .way_valid_i(b_vm),
    .victim_valid_o(b_vv), .victim_way_o(b_vw),
    .update_valid_i(b_uv), .update_set_i(b_us), .update_way_i(b_uw)
  );

  int total = 0;
  int bad   = 0;
  int stamp [2][16][8];
  int tnow  = 0;
  int exp_way [2];

  function automatic int max_stamp(input int d, input int s, input int lo, input int hi);
    int m;
    m = 0;
    for (int w = lo; w < hi; w++) if (stamp[d][s][w] > m) m = stamp[d][s][w];
    return m;
  endfunction

  function automatic int model_victim(input int d, input int s, input int vm);
    int ways, lo, hi, mid;
    ways = (d == 0) ? 4 : 8;
    for (int w = 0; w < ways; w++) if (((vm >> w) & 1) == 0) return w;
    lo = 0;
    hi = ways;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (max_stamp(d, s, lo, mid) > max_stamp(d, s, mid, hi)) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input int expv);
    total++;
    assert (got === 8'(expv)) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, expv);
    end
  endtask

  // One clock cycle on DUT d; the other DUT idles.
  task automatic step(input string tag, input int d, input bit rst_n,
                      input bit lv, input int ls, input int vm,
                      input bit uv, input int us, input int uw);
    bit ev;
    a_rst_n = 1'b1; a_lv = 1'b0; a_uv = 1'b0;
    b_rst_n = 1'b1; b_lv = 1'b0; b_uv = 1'b0;
    if (d == 0) begin
      a_rst_n = rst_n; a_lv = lv; a_ls = 4'(ls); a_vm = 4'(vm);
      a_uv = uv; a_us = 4'(us); a_uw = 2'(uw);
    end else begin
      b_rst_n = rst_n; b_lv = lv; b_ls = 2'(ls); b_vm = 8'(vm);
      b_uv = uv; b_us = 2'(us); b_uw = 3'(uw);
    end
    @(posedge clk);
    ev = 1'b0;
    if (!rst_n) begin
      for (int s = 0; s < 16; s++) for (int w = 0; w < 8; w++) stamp[d][s][w] = 0;
      exp_way[d] = 0;
    end else begin
      if (uv) begin
        tnow++;
        stamp[d][us][uw] = tnow;
      end
      if (lv) exp_way[d] = model_victim(d, ls, vm);
      ev = lv;
    end
    #1;
    if (d == 0) begin
      check({tag, "_vld"}, 8'(a_vv), int'(ev));
      check({tag, "_way"}, 8'(a_vw), exp_way[d]);
    end else begin
      check({tag, "_vld"}, 8'(b_vv), int'(ev));
      check({tag, "_way"}, 8'(b_vw), exp_way[d]);
    end
  endtask

  initial begin
    int ls, us, vm;
    bit rn;
    a_rst_n = 1'b0; a_lv = 1'b0; a_ls = '0; a_vm = '1; a_uv = 1'b0; a_us = '0; a_uw = '0;
    b_rst_n = 1'b0; b_lv = 1'b0; b_ls = '0; b_vm = '1; b_uv = 1'b0; b_us = '0; b_uw = '0;
    exp_way[0] = 0;
    exp_way[1] = 0;

    // 1: reset, then lookup set 3 all valid -> victim 0 for one cycle
    step("rstA", 0, 0, 0, 0, 'hF, 0, 0, 0);
    step("rstA2", 0, 0, 0, 0, 'hF, 0, 0, 0);
    step("t1_lkp", 0, 1, 1, 3, 'hF, 0, 0, 0);
    step("t1_idle", 0, 1, 0, 0, 'hF, 0, 0, 0);
    if (a_vw !== 2'd0) $display("t1 note: victim way not zero");

    // 2: set 5 touched 0,2,1,3 -> victim 0; set 6 untouched -> 0
    step("t2_u0", 0, 1, 0, 0, 'hF, 1, 5, 0);
    step("t2_u2", 0, 1, 0, 0, 'hF, 1, 5, 2);
    step("t2_u1", 0, 1, 0, 0, 'hF, 1, 5, 1);
    step("t2_u3", 0, 1, 0, 0, 'hF, 1, 5, 3);
    step("t2_l5", 0, 1, 1, 5, 'hF, 0, 0, 0);
    step("t2_l6", 0, 1, 1, 6, 'hF, 0, 0, 0);

    // 3: same-cycle update+lookup forwarding, and independent set
    step("t3_fwd", 0, 1, 1, 5, 'hF, 1, 5, 0);
    step("t3_oth", 0, 1, 1, 4, 'hF, 1, 5, 0);

    // 4: invalid ways take priority
    step("t4_1011", 0, 1, 1, 5, 'b1011, 0, 0, 0);
    step("t4_0000", 0, 1, 1, 5, 'b0000, 0, 0, 0);

    // 6: reset in the lookup cycle drops the victim and clears state
    step("t6_pre", 0, 1, 0, 0, 'hF, 1, 7, 0);
    step("t6_rst", 0, 0, 1, 7, 'hF, 0, 0, 0);
    step("t6_lkp", 0, 1, 1, 7, 'hF, 0, 0, 0);

    // 5: 8-way instance
    step("rstB", 1, 0, 0, 0, 'hFF, 0, 0, 0);
    step("t5_u0", 1, 1, 0, 0, 'hFF, 1, 1, 0);
    step("t5_l1", 1, 1, 1, 1, 'hFF, 0, 0, 0);
    step("t5_u4", 1, 1, 0, 0, 'hFF, 1, 1, 4);
    step("t5_l2", 1, 1, 1, 1, 'hFF, 0, 0, 0);

    // random traffic, biased toward same-set forwarding and all-valid masks
    for (int i = 0; i < 400; i++) begin
      us = $urandom_range(0, 15);
      ls = ($urandom_range(0, 1) == 0) ? us : $urandom_range(0, 15);
      vm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 'hF;
      rn = ($urandom_range(0, 49) != 0);
      step("rndA", 0, rn, 1'($urandom_range(0, 1)), ls, vm,
           1'($urandom_range(0, 1)), us, $urandom_range(0, 3));
    end
    for (int i = 0; i < 300; i++) begin
      us = $urandom_range(0, 3);
      ls = ($urandom_range(0, 1) == 0) ? us : $urandom_range(0, 3);
      vm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : 'hFF;
      rn = ($urandom_range(0, 49) != 0);
      step("rndB", 1, rn, 1'($urandom_range(0, 1)), ls, vm,
           1'($urandom_range(0, 1)), us, $urandom_range(0, 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
